// File: rtl/ysyx_23060096_core_seq.sv
// Multi-cycle sequencer for the NPC datapath: fetch, optional DMEM
// access, single-cycle commit strobes, ebreak halt and timeout fault.
module ysyx_23060096_core_seq #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      inst,
    output logic             inst_valid,
    input  logic             dec_ebreak,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    input  logic             dec_rf_wen,
    output logic             dmem_req_valid,
    output logic             dmem_req_we,
    input  logic             dmem_req_ready,
    input  logic             dmem_rsp_valid,
    output logic             rf_wen,
    output logic             pc_wen,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             fault
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IFREQ,
        S_IFWAIT,
        S_EXEC,
        S_MREQ,
        S_MWAIT,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              run;
    logic [31:0]       inst_q;
    logic [TW-1:0]     wcnt;
    logic [CNT_W-1:0]  retired_q;
    logic              wait_exp;
    logic              in_wait;

    assign wait_exp = (wcnt == TW'(TIMEOUT - 1));
    assign in_wait  = (state == S_IFWAIT) || (state == S_MWAIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IFREQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IFREQ: begin
                if (run && imem_req_ready) begin
                    state_nxt = S_IFWAIT;
                end
            end
            S_IFWAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = S_EXEC;
                end else if (wait_exp) begin
                    state_nxt = S_FAULT;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    dec_ebreak:               state_nxt = S_HALT;
                    (dec_mem_rd | dec_mem_wr): state_nxt = S_MREQ;
                    default:                  state_nxt = S_IFREQ;
                endcase
            end
            S_MREQ: begin
                if (dmem_req_ready) begin
                    state_nxt = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (dmem_rsp_valid) begin
                    state_nxt = S_IFREQ;
                end else if (wait_exp) begin
                    state_nxt = S_FAULT;
                end
            end
            S_HALT:  state_nxt = S_HALT;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IFREQ;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_req_we    = 1'b0;
        rf_wen         = 1'b0;
        pc_wen         = 1'b0;
        halted         = 1'b0;
        fault          = 1'b0;
        unique case (state)
            S_IFREQ: begin
                imem_req_valid = run;
            end
            S_IFWAIT: ;
            S_EXEC: begin
                inst_valid = 1'b1;
                if (!dec_ebreak && !dec_mem_rd && !dec_mem_wr) begin
                    rf_wen = dec_rf_wen;
                    pc_wen = 1'b1;
                end
            end
            S_MREQ: begin
                inst_valid     = 1'b1;
                dmem_req_valid = 1'b1;
                dmem_req_we    = dec_mem_wr;
            end
            S_MWAIT: begin
                inst_valid = 1'b1;
                if (dmem_rsp_valid) begin
                    // a store wins when both access flags are set
                    rf_wen = dec_mem_rd & ~dec_mem_wr & dec_rf_wen;
                    pc_wen = 1'b1;
                end
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    // run holds off the first fetch request until one cycle after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run       <= 1'b0;
            inst_q    <= '0;
            wcnt      <= '0;
            retired_q <= '0;
        end else begin
            run <= 1'b1;
            if (state == S_IFWAIT && imem_rsp_valid) begin
                inst_q <= imem_rsp_data;
            end
            if (in_wait && state_nxt == state) begin
                wcnt <= wcnt + TW'(1);
            end else begin
                wcnt <= '0;
            end
            if (pc_wen) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign inst    = inst_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_ysyx_23060096_core_seq.sv
// Directed bench for the core sequencer: commit timing, memory ops,
// halt, timeout fault, mid-transaction reset and counter wrap.
module tb_ysyx_23060096_core_seq;

    localparam logic [31:0] ADDI   = 32'h00100093;
    localparam logic [31:0] LW     = 32'h0000a103;
    localparam logic [31:0] SW     = 32'h0020a023;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk;
    logic        rstn;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        dec_ebreak;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic        dec_rf_wen;
    logic        dmem_req_valid;
    logic        dmem_req_we;
    logic        dmem_req_ready;
    logic        dmem_rsp_valid;
    logic        rf_wen;
    logic        pc_wen;
    logic [3:0]  retired;
    logic        halted;
    logic        fault;

    int checks;
    int errors;

    ysyx_23060096_core_seq #(
        .TIMEOUT(8),
        .CNT_W  (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .dec_ebreak    (dec_ebreak),
        .dec_mem_rd    (dec_mem_rd),
        .dec_mem_wr    (dec_mem_wr),
        .dec_rf_wen    (dec_rf_wen),
        .dmem_req_valid(dmem_req_valid),
        .dmem_req_we   (dmem_req_we),
        .dmem_req_ready(dmem_req_ready),
        .dmem_rsp_valid(dmem_rsp_valid),
        .rf_wen        (rf_wen),
        .pc_wen        (pc_wen),
        .retired       (retired),
        .halted        (halted),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        dec_ebreak     = 1'b0;
        dec_mem_rd     = 1'b0;
        dec_mem_wr     = 1'b0;
        dec_rf_wen     = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
    endtask

    // leaves the DUT in IFREQ with the request already raised
    task automatic do_reset();
        rstn = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // from IFREQ: ready at once, response next cycle; returns in EXEC
    task automatic fetch(input logic [31:0] d, input logic eb,
                         input logic rd, input logic wr, input logic rfw);
        dec_ebreak     = eb;
        dec_mem_rd     = rd;
        dec_mem_wr     = wr;
        dec_rf_wen     = rfw;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        #1;
    endtask

    logic bad;

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        idle();
        @(negedge clk);
        #1;
        chk("rst_req", imem_req_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_ret", retired, 0);
        chk("rst_flags", {halted, fault, pc_wen, rf_wen, dmem_req_valid}, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_req0", imem_req_valid, 0);
        @(negedge clk);
        #1;
        chk("rel_req1", imem_req_valid, 1);

        // addi commits in cycle 3
        fetch(ADDI, 0, 0, 0, 1);
        chk("addi_inst", inst, ADDI);
        chk("addi_iv", inst_valid, 1);
        chk("addi_str", {pc_wen, rf_wen}, 2'b11);
        chk("addi_ret0", retired, 0);
        @(negedge clk);
        #1;
        chk("addi_ret1", retired, 1);
        chk("addi_str0", {pc_wen, rf_wen}, 0);
        chk("addi_req", imem_req_valid, 1);

        // stray responses in IFREQ are ignored
        imem_rsp_valid = 1'b1;
        dmem_rsp_valid = 1'b1;
        #1;
        chk("stray_str", {pc_wen, rf_wen}, 0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        dmem_rsp_valid = 1'b0;
        #1;
        chk("stray_req", imem_req_valid, 1);

        // lw: ready after 2 cycles, response 3 cycles later
        fetch(LW, 0, 1, 0, 1);
        chk("lw_exec", {pc_wen, rf_wen, inst_valid}, 3'b001);
        @(negedge clk);
        #1;
        chk("lw_mreq1", {dmem_req_valid, dmem_req_we}, 2'b10);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        #1;
        chk("lw_mreq2", dmem_req_valid, 1);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        chk("lw_mw1", {dmem_req_valid, pc_wen, rf_wen}, 0);
        @(negedge clk);
        #1;
        chk("lw_mw2", {pc_wen, rf_wen}, 0);
        @(negedge clk);
        dmem_rsp_valid = 1'b1;
        #1;
        chk("lw_commit", {pc_wen, rf_wen}, 2'b11);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        #1;
        chk("lw_after", {pc_wen, rf_wen}, 0);
        chk("lw_ret", retired, 2);

        // sw
        fetch(SW, 0, 0, 1, 0);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        #1;
        chk("sw_we", {dmem_req_valid, dmem_req_we}, 2'b11);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        #1;
        chk("sw_commit", {pc_wen, rf_wen}, 2'b10);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        #1;
        chk("sw_ret", retired, 3);

        // rd and wr both set: store, no rf write
        fetch(SW, 0, 1, 1, 1);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        #1;
        chk("both_we", dmem_req_we, 1);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        #1;
        chk("both_commit", {pc_wen, rf_wen}, 2'b10);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;

        // reset in MWAIT
        fetch(LW, 0, 1, 0, 1);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        chk("mrst_pre", inst_valid, 1);
        rstn = 1'b0;
        dmem_rsp_valid = 1'b1;
        #1;
        chk("mrst_out", {imem_req_valid, inst_valid, dmem_req_valid,
                         pc_wen, rf_wen, halted, fault}, 0);
        chk("mrst_inst", inst, 0);
        chk("mrst_ret", retired, 0);
        idle();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("mrst_rel0", imem_req_valid, 0);
        @(negedge clk);
        #1;
        chk("mrst_rel1", imem_req_valid, 1);
        chk("mrst_ret1", retired, 0);

        // request held while ready low, then 17 ALU ops wrap counter
        bad = 1'b0;
        repeat (5) begin
            #1;
            if (!imem_req_valid) bad = 1'b1;
            @(negedge clk);
        end
        chk("req_hold", bad, 0);
        for (int k = 1; k <= 17; k++) begin
            fetch(ADDI, 0, 0, 0, 1);
            @(negedge clk);
            #1;
            if (k == 16) chk("wrap0", retired, 0);
        end
        chk("wrap1", retired, 1);

        // fetch timeout
        do_reset();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        chk("ito_pre", fault, 0);
        @(negedge clk);
        #1;
        chk("ito_fault", fault, 1);
        chk("ito_req", imem_req_valid, 0);
        imem_rsp_valid = 1'b1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        #1;
        chk("ito_sticky", {fault, inst_valid}, 2'b10);

        // response on the threshold cycle wins
        do_reset();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        repeat (7) @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ADDI;
        dec_rf_wen     = 1'b1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        #1;
        chk("race_fault", fault, 0);
        chk("race_inst", inst, ADDI);
        chk("race_commit", pc_wen, 1);
        @(negedge clk);

        // data timeout
        fetch(LW, 0, 1, 0, 1);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        chk("dto_pre", fault, 0);
        @(negedge clk);
        #1;
        chk("dto_fault", {fault, pc_wen, dmem_req_valid}, 3'b100);

        // ebreak halts
        do_reset();
        fetch(EBREAK, 1, 0, 0, 1);
        chk("eb_exec", {pc_wen, rf_wen}, 0);
        @(negedge clk);
        #1;
        chk("eb_halt", halted, 1);
        chk("eb_ret", retired, 0);
        imem_req_ready = 1'b1;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if (imem_req_valid || pc_wen || !halted) bad = 1'b1;
        end
        chk("eb_quiet", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
